// File: rtl/fir_mac_sequencer_pkg.sv
// Shared definitions for the serial-MAC FIR sequencer: FSM state encoding
// and a constant clog2 helper for deriving address widths.
package fir_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample/result handshakes plus the MAC/RAM control bundle driven by the sequencer.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
interface fir_mac_sequencer_if #(
  parameter int AW = 3
);
  logic          i_valid;
  logic          o_ready;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [AW-1:0] o_smp_addr;
  logic [AW-1:0] o_coef_addr;
  logic          o_mac_en;
  logic          o_first;
  logic          o_last;
  logic          o_valid;
  logic          i_ready;
  logic          o_busy;

  modport master (
    output i_valid, i_ready,
    input  o_ready, o_wr_en, o_wr_addr, o_smp_addr, o_coef_addr,
           o_mac_en, o_first, o_last, o_valid, o_busy
  );

  modport slave (
    input  i_valid, i_ready,
    output o_ready, o_wr_en, o_wr_addr, o_smp_addr, o_coef_addr,
           o_mac_en, o_first, o_last, o_valid, o_busy
  );
endinterface

// File: rtl/fir_ring_addr.sv
// Circular sample-RAM address for tap k: (newest - k) mod NTAPS, valid for any
// NTAPS <= 2**AW (no power-of-two assumption).
module fir_ring_addr
  import fir_mac_sequencer_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int AW    = 3
) (
  input  logic [AW-1:0] newest,
  input  logic [AW-1:0] k,
  output logic [AW-1:0] addr
);
  // When newest < k the true result lies in [0, NTAPS), so AW-bit wrap is exact.
  assign addr = (newest >= k) ? (newest - k) : (newest + AW'(NTAPS) - k);
endmodule

// File: rtl/fir_mac_sequencer.sv
// Control FSM for a single-multiplier FIR: writes each sample to the ring RAM,
// issues one tap per cycle, waits out the MAC latency, then hands off the result.
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int NTAPS   = 8,
  parameter int AW      = 3,
  parameter int MAC_LAT = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  fir_mac_sequencer_if.slave    bus,
  output state_t                o_state
);
  localparam int            DW         = (MAC_LAT > 1) ? clog2(MAC_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
  localparam logic [AW-1:0] LAST_TAP   = AW'(NTAPS - 1);

  state_t        state, nxt_state;
  logic [AW-1:0] wptr, nxt_wptr;
  logic [AW-1:0] newest, nxt_newest;
  logic [AW-1:0] tap, nxt_tap;
  logic [DW-1:0] drain_cnt, nxt_drain_cnt;
  logic          accept;
  logic [AW-1:0] ring_addr;

  logic          nxt_mac_en, nxt_first, nxt_last, nxt_valid;
  logic [AW-1:0] nxt_smp, nxt_coef;
  logic          mac_en_q, first_q, last_q, valid_q;
  logic [AW-1:0] smp_q, coef_q;

  assign accept = bus.i_valid && (state == ST_IDLE);

  // State register together with the registered control outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      wptr      <= '0;
      newest    <= '0;
      tap       <= '0;
      drain_cnt <= '0;
      mac_en_q  <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      smp_q     <= '0;
      coef_q    <= '0;
    end else begin
      state     <= nxt_state;
      wptr      <= nxt_wptr;
      newest    <= nxt_newest;
      tap       <= nxt_tap;
      drain_cnt <= nxt_drain_cnt;
      mac_en_q  <= nxt_mac_en;
      first_q   <= nxt_first;
      last_q    <= nxt_last;
      valid_q   <= nxt_valid;
      smp_q     <= nxt_smp;
      coef_q    <= nxt_coef;
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_wptr      = wptr;
    nxt_newest    = newest;
    nxt_tap       = tap;
    nxt_drain_cnt = drain_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          nxt_newest = wptr;
          nxt_wptr   = (wptr == LAST_TAP) ? '0 : wptr + 1'b1;
          nxt_tap    = '0;
          nxt_state  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tap == LAST_TAP) begin
          nxt_tap       = '0;
          nxt_drain_cnt = '0;
          nxt_state     = (MAC_LAT == 0) ? ST_OUT : ST_DRAIN;
        end else begin
          nxt_tap = tap + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) nxt_state = ST_OUT;
        else                         nxt_drain_cnt = drain_cnt + 1'b1;
      end
      ST_OUT: begin
        if (bus.i_ready) nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  fir_ring_addr #(.NTAPS(NTAPS), .AW(AW)) u_ring_addr (
    .newest (nxt_newest),
    .k      (nxt_tap),
    .addr   (ring_addr)
  );

  // Outputs are computed for the coming state so they can be registered.
  always_comb begin
    nxt_mac_en = (nxt_state == ST_RUN);
    nxt_first  = nxt_mac_en && (nxt_tap == '0);
    nxt_last   = nxt_mac_en && (nxt_tap == LAST_TAP);
    nxt_valid  = (nxt_state == ST_OUT);
    nxt_smp    = nxt_mac_en ? ring_addr : '0;
    nxt_coef   = nxt_mac_en ? nxt_tap : '0;
  end

  assign bus.o_ready     = (state == ST_IDLE);
  assign bus.o_busy      = (state != ST_IDLE);
  assign bus.o_wr_en     = accept;
  assign bus.o_wr_addr   = wptr;
  assign bus.o_smp_addr  = smp_q;
  assign bus.o_coef_addr = coef_q;
  assign bus.o_mac_en    = mac_en_q;
  assign bus.o_first     = first_q;
  assign bus.o_last      = last_q;
  assign bus.o_valid     = valid_q;
  assign o_state         = state;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench: an 8-tap/latency-2 sequencer and a 5-tap/latency-0 sequencer
// driven through tap sequences, backpressure, pointer wrap and mid-run reset.
module tb_fir_mac_sequencer;
  import fir_mac_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [2:0] exp_q[$];
  state_t a_state, b_state;

  fir_mac_sequencer_if #(.AW(3)) a_if ();
  fir_mac_sequencer_if #(.AW(3)) b_if ();

  fir_mac_sequencer #(.NTAPS(8), .AW(3), .MAC_LAT(2)) dut_a (
    .i_clk (clk), .i_reset (rst), .bus (a_if.slave), .o_state (a_state)
  );
  fir_mac_sequencer #(.NTAPS(5), .AW(3), .MAC_LAT(0)) dut_b (
    .i_clk (clk), .i_reset (rst), .bus (b_if.slave), .o_state (b_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_smp(input string tag, input logic [2:0] got);
    if (exp_q.size() == 0) check(tag, {29'd0, got}, 32'hFFFF_FFFF);
    else                   check(tag, {29'd0, got}, {29'd0, exp_q.pop_front()});
  endtask

  task automatic push_ring8(input int w);
    for (int k = 0; k < 8; k++) exp_q.push_back(3'((w + 8 - k) % 8));
  endtask

  // One full sample on the 8-tap unit, starting in an IDLE cycle.
  task automatic run_a(input logic [2:0] wa, input int stall, input bit hold_valid);
    a_if.i_valid = 1'b1;
    #1;
    check("a_idle_state", a_state, ST_IDLE);
    check("a_wr_en", a_if.o_wr_en, 1);
    check("a_wr_addr", a_if.o_wr_addr, wa);
    tick();
    a_if.i_valid = hold_valid;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("a_mac_en", a_if.o_mac_en, 1);
      check("a_coef", a_if.o_coef_addr, k);
      check_smp("a_smp", a_if.o_smp_addr);
      check("a_first", a_if.o_first, (k == 0));
      check("a_last", a_if.o_last, (k == 7));
      check("a_ready_run", a_if.o_ready, 0);
      check("a_wr_en_run", a_if.o_wr_en, 0);
      check("a_valid_run", a_if.o_valid, 0);
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      check("a_drain_state", a_state, ST_DRAIN);
      check("a_drain_mac", a_if.o_mac_en, 0);
      check("a_drain_valid", a_if.o_valid, 0);
      check("a_drain_busy", a_if.o_busy, 1);
      tick();
    end
    for (int s = 0; s < stall; s++) begin
      check("a_stall_valid", a_if.o_valid, 1);
      check("a_stall_ready", a_if.o_ready, 0);
      check("a_stall_wr_en", a_if.o_wr_en, 0);
      check("a_stall_mac", a_if.o_mac_en, 0);
      tick();
    end
    check("a_out_valid", a_if.o_valid, 1);
    check("a_out_state", a_state, ST_OUT);
    a_if.i_ready = 1'b1;
    tick();
    a_if.i_ready = 1'b0;
    #1;
    check("a_post_valid", a_if.o_valid, 0);
    check("a_post_ready", a_if.o_ready, 1);
    check("a_post_busy", a_if.o_busy, 0);
  endtask

  // One full sample on the 5-tap, zero-latency unit.
  task automatic run_b(input logic [2:0] wa);
    b_if.i_valid = 1'b1;
    #1;
    check("b_wr_en", b_if.o_wr_en, 1);
    check("b_wr_addr", b_if.o_wr_addr, wa);
    tick();
    b_if.i_valid = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("b_mac_en", b_if.o_mac_en, 1);
      check("b_coef", b_if.o_coef_addr, k);
      check_smp("b_smp", b_if.o_smp_addr);
      check("b_first", b_if.o_first, (k == 0));
      check("b_last", b_if.o_last, (k == 4));
      tick();
    end
    check("b_out_valid", b_if.o_valid, 1);
    check("b_out_mac", b_if.o_mac_en, 0);
    check("b_out_state", b_state, ST_OUT);
    b_if.i_ready = 1'b1;
    tick();
    b_if.i_ready = 1'b0;
    #1;
    check("b_post_valid", b_if.o_valid, 0);
    check("b_post_ready", b_if.o_ready, 1);
  endtask

  initial begin
    int seen_valid;
    a_if.i_valid = 1'b0;
    a_if.i_ready = 1'b0;
    b_if.i_valid = 1'b0;
    b_if.i_ready = 1'b0;

    // Reset for two cycles
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", a_if.o_ready, 1);
    check("rst_busy", a_if.o_busy, 0);
    check("rst_valid", a_if.o_valid, 0);
    check("rst_mac_en", a_if.o_mac_en, 0);
    check("rst_wr_en", a_if.o_wr_en, 0);
    check("rst_first", a_if.o_first, 0);
    check("rst_last", a_if.o_last, 0);
    check("rst_smp", a_if.o_smp_addr, 0);
    check("rst_coef", a_if.o_coef_addr, 0);
    check("rst_wr_addr", a_if.o_wr_addr, 0);
    check("rst_state", a_state, ST_IDLE);
    check("rst_b_ready", b_if.o_ready, 1);
    check("rst_b_valid", b_if.o_valid, 0);

    // Single sample, newest = 0
    exp_q = '{3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    run_a(3'd0, 0, 1'b0);

    // Backpressure with i_valid held high, then the next sample is taken
    exp_q = '{3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
    run_a(3'd1, 5, 1'b1);
    check("a_bp_next_wr_en", a_if.o_wr_en, 1);
    check("a_bp_next_addr", a_if.o_wr_addr, 2);
    exp_q = '{3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
    run_a(3'd2, 0, 1'b0);

    // Reset asserted during tap 3
    a_if.i_valid = 1'b1;
    tick();
    a_if.i_valid = 1'b0;
    tick();
    tick();
    tick();
    check("a_mid_coef", a_if.o_coef_addr, 3);
    check("a_mid_mac", a_if.o_mac_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("a_rst_mac", a_if.o_mac_en, 0);
    check("a_rst_ready", a_if.o_ready, 1);
    check("a_rst_busy", a_if.o_busy, 0);
    check("a_rst_valid", a_if.o_valid, 0);
    check("a_rst_wr_addr", a_if.o_wr_addr, 0);
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_if.o_valid) seen_valid++;
      tick();
    end
    check("a_rst_no_valid", seen_valid, 0);

    // Nine samples back to back: write pointer wraps to 0
    for (int i = 0; i < 9; i++) begin
      push_ring8(i % 8);
      run_a(3'(i % 8), 0, 1'b0);
    end

    // Five-tap ring: newest = 1 gives 1,0,4,3,2
    exp_q = '{3'd0, 3'd4, 3'd3, 3'd2, 3'd1};
    run_b(3'd0);
    exp_q = '{3'd1, 3'd0, 3'd4, 3'd3, 3'd2};
    run_b(3'd1);

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
